// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned JUMP_TGT_W       = 26;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One outstanding fetch: request, wait for data, present to the decoder.
    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC computation for the presented instruction: jump, taken branch or sequential.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [31:0]           InstrPC,
    input  logic                  Branch,
    input  logic [31:0]           BranchOffset,
    input  logic                  Jump,
    input  logic [JUMP_TGT_W-1:0] JumpTarget,
    output logic [31:0]           NextPC
);

    logic [31:0] seq_pc;

    // Jump outranks branch; branch offset counts words relative to the sequential PC.
    always_comb begin
        seq_pc = InstrPC + PC_STEP;
        NextPC = seq_pc;
        if (Jump) begin
            NextPC = {seq_pc[31:28], JumpTarget, 2'b00};
        end else if (Branch) begin
            NextPC = seq_pc + (BranchOffset << 2);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Stall-tolerant instruction fetch sequencer: one outstanding memory request, one
// instruction presented to the decoder at a time, PC redirected on accept.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic                  ImemReq,
    output logic [31:0]           ImemAddr,
    input  logic                  ImemReady,
    input  logic                  ImemRspValid,
    input  logic [31:0]           ImemRspData,
    output logic [31:0]           Instruction,
    output logic                  InstrValid,
    input  logic                  InstrAccept,
    output logic [31:0]           InstrPC,
    input  logic                  Branch,
    input  logic [31:0]           BranchOffset,
    input  logic                  Jump,
    input  logic [JUMP_TGT_W-1:0] JumpTarget,
    output logic [31:0]           RetiredCount
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  retired_q, retired_d;
    logic [31:0]  next_pc;

    next_pc_calc #(
        .PC_STEP (PC_STEP)
    ) u_next_pc_calc (
        .InstrPC      (instr_pc_q),
        .Branch       (Branch),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .NextPC       (next_pc)
    );

    // Request is decoded from state only, so memory inputs never reach it combinationally.
    assign ImemReq      = (state_q == FETCH);
    assign ImemAddr     = pc_q;
    assign Instruction  = instr_q;
    assign InstrValid   = valid_q;
    assign InstrPC      = instr_pc_q;
    assign RetiredCount = retired_q;

    // Next-state and datapath updates; redirects only matter on the accepting HOLD cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        retired_d  = retired_q;
        unique case (state_q)
            FETCH: begin
                if (ImemReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ImemRspValid) begin
                    state_d    = HOLD;
                    instr_d    = ImemRspData;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                end
            end
            HOLD: begin
                if (InstrAccept) begin
                    state_d   = FETCH;
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            retired_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            retired_q  <= retired_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of fetch transactions with hand-computed
// addresses, plus hand-written async reset sequences. A second instance with a reset PC
// at the top of the address space checks sequential wrap.
module tb_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        ImemReady;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        InstrAccept;
    logic        Branch;
    logic [31:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpTarget;

    logic        ImemReq,  ImemReq2;
    logic [31:0] ImemAddr, ImemAddr2;
    logic [31:0] Instruction, Instruction2;
    logic        InstrValid, InstrValid2;
    logic [31:0] InstrPC, InstrPC2;
    logic [31:0] RetiredCount, RetiredCount2;

    int checks = 0;
    int errors = 0;
    int retired_exp = 0;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .InstrAccept  (InstrAccept),
        .InstrPC      (InstrPC),
        .Branch       (Branch),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .RetiredCount (RetiredCount)
    );

    fetch_sequencer #(
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (32'd4)
    ) dut_wrap (
        .Clk          (Clk),
        .Reset        (Reset),
        .ImemReq      (ImemReq2),
        .ImemAddr     (ImemAddr2),
        .ImemReady    (ImemReady),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .Instruction  (Instruction2),
        .InstrValid   (InstrValid2),
        .InstrAccept  (InstrAccept),
        .InstrPC      (InstrPC2),
        .Branch       (Branch),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .RetiredCount (RetiredCount2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          ready_dly;
        int          rsp_dly;
        int          acc_dly;
        logic [31:0] addr;
        logic [31:0] data;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] tgt;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One full fetch/wait/hold transaction with optional stalls and the given redirect.
    task automatic txn(input vec_t v);
        check("fetch_req", {31'h0, ImemReq}, 32'h1);
        check("fetch_addr", ImemAddr, v.addr);
        ImemReady = 1'b0;
        for (int k = 0; k < v.ready_dly; k++) begin
            ImemRspValid = 1'b1;          // stray response in FETCH must be ignored
            ImemRspData  = 32'hDEAD_BEEF;
            tick();
            check("stall_req", {31'h0, ImemReq}, 32'h1);
            check("stall_addr", ImemAddr, v.addr);
            check("stall_valid", {31'h0, InstrValid}, 32'h0);
        end
        ImemRspValid = 1'b0;
        ImemReady    = 1'b1;
        tick();
        ImemReady = 1'b0;
        check("wait_req", {31'h0, ImemReq}, 32'h0);
        check("wait_valid", {31'h0, InstrValid}, 32'h0);
        for (int k = 0; k < v.rsp_dly; k++) begin
            tick();
            check("wait_stall_req", {31'h0, ImemReq}, 32'h0);
            check("wait_stall_valid", {31'h0, InstrValid}, 32'h0);
        end
        ImemRspValid = 1'b1;
        ImemRspData  = v.data;
        tick();
        ImemRspValid = 1'b0;
        ImemRspData  = 32'h5A5A_5A5A;
        check("hold_valid", {31'h0, InstrValid}, 32'h1);
        check("hold_instr", Instruction, v.data);
        check("hold_pc", InstrPC, v.addr);
        for (int k = 0; k < v.acc_dly; k++) begin
            ImemRspValid = 1'b1;          // stray response in HOLD must be ignored
            ImemRspData  = 32'hBAD0_0000 + k;
            Branch       = 1'b1;
            Jump         = 1'b1;
            JumpTarget   = 26'h3FF_FFFF;
            tick();
            check("hold_stall_valid", {31'h0, InstrValid}, 32'h1);
            check("hold_stall_instr", Instruction, v.data);
            check("hold_stall_pc", InstrPC, v.addr);
            check("hold_stall_retired", RetiredCount, retired_exp);
            check("hold_stall_req", {31'h0, ImemReq}, 32'h0);
        end
        ImemRspValid = 1'b0;
        Branch       = v.br;
        BranchOffset = v.off;
        Jump         = v.jmp;
        JumpTarget   = v.tgt;
        InstrAccept  = 1'b1;
        tick();
        InstrAccept  = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        BranchOffset = 32'h0;
        JumpTarget   = 26'h0;
        retired_exp++;
        check("accept_valid", {31'h0, InstrValid}, 32'h0);
        check("accept_retired", RetiredCount, retired_exp);
    endtask

    initial begin
        // addr is the expected fetch address of each record, i.e. the next-PC of the previous.
        vecs[0]  = '{0, 0, 0, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 26'h0};
        vecs[1]  = '{0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 26'h0};
        vecs[2]  = '{0, 0, 0, 32'h0000_0008, 32'h2222_2222, 1'b0, 32'h0,         1'b0, 26'h0};
        vecs[3]  = '{0, 0, 0, 32'h0000_000C, 32'h3333_3333, 1'b0, 32'h0,         1'b0, 26'h0};
        vecs[4]  = '{3, 2, 5, 32'h0000_0010, 32'h4444_4444, 1'b0, 32'h0,         1'b0, 26'h0};
        vecs[5]  = '{0, 0, 0, 32'h0000_0014, 32'h5555_5555, 1'b0, 32'h0,         1'b1, 26'h8};
        vecs[6]  = '{0, 0, 0, 32'h0000_0020, 32'h6666_6666, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0};
        vecs[7]  = '{0, 0, 0, 32'h0000_0014, 32'h7777_7777, 1'b0, 32'h0,         1'b1, 26'h8};
        vecs[8]  = '{0, 1, 1, 32'h0000_0020, 32'h8888_8888, 1'b1, 32'h0000_0003, 1'b0, 26'h0};
        vecs[9]  = '{0, 0, 0, 32'h0000_0030, 32'h9999_9999, 1'b1, 32'h0400_0003, 1'b0, 26'h0};
        vecs[10] = '{0, 0, 0, 32'h1000_0040, 32'hAAAA_AAAA, 1'b1, 32'h0000_0005, 1'b1, 26'h100};
        vecs[11] = '{1, 0, 0, 32'h1000_0400, 32'hBBBB_BBBB, 1'b0, 32'h0,         1'b0, 26'h0};

        Reset        = 1'b0;
        ImemReady    = 1'b0;
        ImemRspValid = 1'b0;
        ImemRspData  = 32'h0;
        InstrAccept  = 1'b0;
        Branch       = 1'b0;
        BranchOffset = 32'h0;
        Jump         = 1'b0;
        JumpTarget   = 26'h0;

        #3;
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc", InstrPC, 32'h0);
        check("rst_valid", {31'h0, InstrValid}, 32'h0);
        check("rst_retired", RetiredCount, 32'h0);
        check("rst_addr", ImemAddr, 32'h0);
        check("rst_req", {31'h0, ImemReq}, 32'h1);

        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("wrap_first_addr", ImemAddr2, 32'hFFFF_FFFC);

        for (int i = 0; i < NVEC; i++) begin
            if (i == 1) begin
                check("wrap_second_addr", ImemAddr2, 32'h0000_0000);
                check("wrap_second_req", {31'h0, ImemReq2}, 32'h1);
            end
            if (i == 4) begin
                check("seq_retired4", RetiredCount, 32'd4);
            end
            txn(vecs[i]);
        end
        check("final_addr", ImemAddr, 32'h1000_0404);

        // Async reset while waiting for a response.
        ImemReady = 1'b1;
        tick();
        ImemReady = 1'b0;
        check("pre_rst_wait_req", {31'h0, ImemReq}, 32'h0);
        #3;
        Reset = 1'b0;
        #1;
        check("async_wait_retired", RetiredCount, 32'h0);
        check("async_wait_valid", {31'h0, InstrValid}, 32'h0);
        check("async_wait_req", {31'h0, ImemReq}, 32'h1);
        check("async_wait_addr", ImemAddr, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        retired_exp = 0;
        check("post_rst_addr2", ImemAddr2, 32'hFFFF_FFFC);

        // Async reset while an instruction is held.
        ImemReady = 1'b1;
        tick();
        ImemReady    = 1'b0;
        ImemRspValid = 1'b1;
        ImemRspData  = 32'hCAFE_F00D;
        tick();
        ImemRspValid = 1'b0;
        check("pre_rst_hold_valid", {31'h0, InstrValid}, 32'h1);
        check("pre_rst_hold_instr", Instruction, 32'hCAFE_F00D);
        #3;
        Reset = 1'b0;
        #1;
        check("async_hold_valid", {31'h0, InstrValid}, 32'h0);
        check("async_hold_instr", Instruction, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("post_rst_req", {31'h0, ImemReq}, 32'h1);
        check("post_rst_addr", ImemAddr, 32'h0);
        tick();
        check("post_rst_held_req", {31'h0, ImemReq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
